// File: rtl/gpu_framebuffer.sv
// gpu_framebuffer: dual-port pixel store with CPU MMIO port, scan port and solid-colour fill engine
module gpu_framebuffer #(
  parameter int ADDR_W   = 16,
  parameter int FB_DEPTH = 19200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [7:0]        cpu_wdata_i,
  input  logic              cpu_we_i,
  input  logic              cpu_re_i,
  output logic              cpu_ready_o,
  output logic [7:0]        cpu_rdata_o,
  output logic              cpu_rvalid_o,
  input  logic              fill_start_i,
  input  logic [ADDR_W-1:0] fill_base_i,
  input  logic [ADDR_W-1:0] fill_len_i,
  input  logic [7:0]        fill_color_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  input  logic [ADDR_W-1:0] pixel_addr_i,
  input  logic              in_disp_i,
  output logic [7:0]        pixel_data_o
);
  localparam int IDX_W = $clog2(FB_DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FB_DEPTH - 1);
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2;
  logic [7:0] mem [FB_DEPTH];
  logic [1:0] state;
  logic [ADDR_W-1:0] cur_addr, remaining, waddr;
  logic [7:0] color, wdata;
  logic cpu_rd, mem_we;
  assign cpu_ready_o = state == IDLE;
  assign fill_busy_o = state == FILL;
  assign fill_done_o = state == DONE;
  // CPU and fill never share a cycle, so one write port serves both; reset blocks any write
  always_comb begin
    cpu_rd = cpu_ready_o & cpu_re_i & ~cpu_we_i;
    mem_we = ~rst & (fill_busy_o | (cpu_ready_o & cpu_we_i & (cpu_addr_i < DEPTH_A)));
    waddr = fill_busy_o ? cur_addr : cpu_addr_i;
    wdata = fill_busy_o ? color : cpu_wdata_i;
  end
  always_ff @(posedge clk)
    if (mem_we) mem[waddr[IDX_W-1:0]] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pixel_data_o <= 8'h00;
      cpu_rdata_o <= 8'h00;
      cpu_rvalid_o <= 1'b0;
    end else begin
      pixel_data_o <= (in_disp_i && pixel_addr_i < DEPTH_A) ? mem[pixel_addr_i[IDX_W-1:0]] : 8'h00;
      cpu_rvalid_o <= cpu_rd;
      if (cpu_rd) cpu_rdata_o <= (cpu_addr_i < DEPTH_A) ? mem[cpu_addr_i[IDX_W-1:0]] : 8'h00;
      if (state == IDLE && fill_start_i) begin
        cur_addr <= fill_base_i;
        remaining <= fill_len_i;
        color <= fill_color_i;
        state <= (fill_len_i == '0 || fill_base_i >= DEPTH_A) ? DONE : FILL;
      end else if (state == FILL) begin
        cur_addr <= cur_addr + 1'b1;
        remaining <= remaining - 1'b1;
        if (remaining == ADDR_W'(1) || cur_addr == LAST_A) state <= DONE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule
